gb_fb_writer: RTL and testbench
===============================

Name: gb_fb_writer

Overview:
- Pixel sink directly downstream of the PPU pixel FIFO.
- Consumes 2-bit colour indices (px_in/px_valid), maps them through BGP to shades and packs 16 pixels per 32-bit word.
- Writes packed words into a 160x144 framebuffer through an Avalon-MM write master, so the VGA/HPS side can scan it out.
- Line and frame framing come from the PPU mode output; a small internal FIFO absorbs slave backpressure.

Parameters:
FB_BASE, 32'h0000_0000, byte address of framebuffer pixel (0,0)
FIFO_DEPTH, 4, pending-write entries (power of 2, >=2)
LINE_PX, 160, visible pixels per line
LINES, 144, visible lines per frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (low = reset, sampled on rising clk)
lcd_en  in  1  LCDC[7]; 0 forces idle
ppu_mode  in  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
bgp  in  8  BG palette register
px_in  in  2  colour index from PPU
px_valid  in  1  px_in valid this cycle
fb_address  out  32  Avalon byte address
fb_writedata  out  32  packed shades
fb_write  out  1  Avalon write request
fb_waitrequest  in  1  Avalon backpressure
frame_done  out  1  one-cycle pulse at end of frame
overflow  out  1  sticky: word dropped because FIFO was full

Behaviour:
- Reset (rst==0 at an edge): fb_write=0, fb_address=FB_BASE, fb_writedata=0, frame_done=0, overflow=0, x=0, y=0, word_idx=0, pack register=0, FIFO emptied. Pending writes are discarded, including mid-transaction.
- Shade mapping: shade = bgp[2*px_in+1 : 2*px_in].
- Pixel accept:
  - Condition: px_valid && lcd_en && ppu_mode==3 && x<LINE_PX && y<LINES.
  - Shade goes into pack bits [2*(x%16)+1 : 2*(x%16)]; x increments.
  - Pixels outside these conditions are dropped silently.
- Word complete: when x%16==15 is accepted, the word (pack with the new shade) is pushed with address FB_BASE + 4*(y*10 + word_idx). word_idx increments and the pack register clears.
- Line end (ppu_mode changes 3 -> 0): if x%16 != 0, flush the partial word with zero padding (upper bits 0). Then x=0, word_idx=0, y=y+1 (saturates at LINES).
  - Simultaneous accept on the same cycle as the mode change cannot occur, because accept requires mode 3. A pixel on the last DRAW cycle is packed before the following cycle's flush.
- Frame end (ppu_mode changes to 1, or y reaches LINES): y=0. frame_done pulses high for exactly one cycle on the first such cycle per frame.
- lcd_en==0:
  - Counters and pack register are cleared.
  - No new pushes and no frame_done.
  - The FIFO keeps draining.
- FIFO: sub-module, first-word-fall-through, entries {addr[31:0], data[31:0]}.
  - Push while full: entry dropped, overflow<=1. overflow is cleared only by reset.
  - Push and pop in the same cycle while full: allowed, no overflow.
- Avalon master:
  - fb_write = FIFO non-empty; fb_address/fb_writedata = FIFO head.
  - Pop when fb_write && !fb_waitrequest.
  - Address and data are held stable while waitrequest is high.
- Latency: 16th pixel accepted in cycle N -> fb_write high in cycle N+1 (FIFO previously empty, waitrequest low). Throughput is 1 word/cycle.
- Widths: y*10 is computed in 16 bits, and the address sum in 32 bits with wrap-around modulo 2^32.
- The per-line word count is fixed at LINE_PX/16 = 10.

Decomposition:
- Shared package gb_ppu_pkg: PPU_STATES_t enum (H_BLANK, V_BLANK, SCAN, DRAW) and constants LINE_PX, LINES, WORDS_PER_LINE=10.
- Sub-module gb_fb_fifo: parameterised FWFT sync FIFO, with full/empty flags and 64-bit data.
- Top-level gb_fb_writer holds the pack/counter logic and the Avalon handshake.

Test Plan:
- bgp=8'hE4, mode=3, 16 valid px all index 1, waitrequest=0 -> one write, addr=FB_BASE, data=32'h5555_5555, fb_write high exactly 1 cycle.
- bgp=8'h1B (reverse), indices 0,1,2,3 repeated over 160 px on line 0 -> 10 writes, addrs FB_BASE+0..+36, each data=32'h1B1B_1B1B.
- 5 px of index 3 with bgp=8'hE4, then mode 3->0 -> flush write data=32'h0000_03FF at addr FB_BASE; next line's first word goes to FB_BASE+40.
- waitrequest held high 20 cycles while 96 px stream in -> 4 words queued, 5th and 6th dropped, overflow=1. The head address/data stays stable; after release the 4 queued words are written in order.
- 144 full lines, then mode->1 -> 1440 writes, last addr FB_BASE+5756; frame_done high exactly 1 cycle; next frame restarts at FB_BASE.
- rst driven low mid-line with 2 entries queued and waitrequest high -> next cycle fb_write=0, overflow=0; the next accepted word goes to FB_BASE.

Source files
------------

// File: rtl/gb_ppu_pkg.sv
// Shared PPU definitions: mode encoding, visible geometry and palette lookup.
package gb_ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    localparam int LINE_PX        = 160;
    localparam int LINES          = 144;
    localparam int WORDS_PER_LINE = 10;

    function automatic logic [1:0] bgp_shade(input logic [7:0] bgp, input logic [1:0] idx);
        return bgp[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/gb_fb_fifo.sv
// First-word-fall-through sync FIFO holding pending framebuffer writes {addr, data}.
module gb_fb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    import gb_ppu_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push && (!full || do_pop);
        drop     = push && !do_push;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/gb_fb_writer.sv
// PPU pixel sink: palette-maps colour indices, packs 16 shades per word and
// streams the words into the framebuffer through an Avalon-MM write master.
module gb_fb_writer #(
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          LINE_PX    = gb_ppu_pkg::LINE_PX,
    parameter int          LINES      = gb_ppu_pkg::LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_en,
    input  logic [1:0]  ppu_mode,
    input  logic [7:0]  bgp,
    input  logic [1:0]  px_in,
    input  logic        px_valid,
    output logic [31:0] fb_address,
    output logic [31:0] fb_writedata,
    output logic        fb_write,
    input  logic        fb_waitrequest,
    output logic        frame_done,
    output logic        overflow
);
    import gb_ppu_pkg::*;

    localparam int X_W = $clog2(LINE_PX + 1);
    localparam int Y_W = $clog2(LINES + 1);
    localparam logic [X_W-1:0] LINE_PX_X = X_W'(LINE_PX);
    localparam logic [Y_W-1:0] LINES_Y   = Y_W'(LINES);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [3:0]     word_idx_q, word_idx_d;
    logic [31:0]    pack_q, pack_d;
    logic [1:0]     mode_q, mode_d;
    logic           armed_q, armed_d;
    logic           frame_done_q, frame_done_d;
    logic           overflow_q, overflow_d;

    logic           accept, line_end, frame_end;
    logic           push, pop;
    logic [31:0]    push_addr, push_data;
    logic [15:0]    lin_word;
    logic [63:0]    fifo_head;
    logic           fifo_full, fifo_empty, fifo_drop;

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        word_idx_d   = word_idx_q;
        pack_d       = pack_q;
        mode_d       = ppu_mode;
        armed_d      = armed_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | fifo_drop;
        push         = 1'b0;
        push_data    = pack_q;

        accept    = px_valid && lcd_en && (ppu_mode == DRAW) &&
                    (x_q < LINE_PX_X) && (y_q < LINES_Y);
        line_end  = lcd_en && (mode_q == DRAW) && (ppu_mode == H_BLANK);
        frame_end = lcd_en && (((ppu_mode == V_BLANK) && (mode_q != V_BLANK)) ||
                               (y_q == LINES_Y));

        lin_word  = 16'(y_q) * 16'(WORDS_PER_LINE) + 16'(word_idx_q);
        push_addr = FB_BASE + {14'd0, lin_word, 2'b00};

        if (!lcd_en) begin
            x_d        = '0;
            y_d        = '0;
            word_idx_d = '0;
            pack_d     = '0;
        end else begin
            // Any DRAW activity re-arms frame_done so each frame pulses it once.
            if (ppu_mode == DRAW) begin
                armed_d = 1'b1;
            end
            if (accept) begin
                push_data[{x_q[3:0], 1'b0} +: 2] = bgp_shade(bgp, px_in);
                x_d = x_q + 1'b1;
                if (x_q[3:0] == 4'hF) begin
                    push       = 1'b1;
                    pack_d     = '0;
                    word_idx_d = word_idx_q + 1'b1;
                end else begin
                    pack_d = push_data;
                end
            end
            if (line_end) begin
                // Unused upper pack bits are already zero, giving the padding.
                push       = (x_q[3:0] != 4'h0);
                push_data  = pack_q;
                x_d        = '0;
                word_idx_d = '0;
                pack_d     = '0;
                if (y_q < LINES_Y) begin
                    y_d = y_q + 1'b1;
                end
            end
            if (frame_end) begin
                y_d = '0;
                if (armed_q) begin
                    frame_done_d = 1'b1;
                    armed_d      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q          <= '0;
            y_q          <= '0;
            word_idx_q   <= '0;
            pack_q       <= '0;
            mode_q       <= H_BLANK;
            armed_q      <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            word_idx_q   <= word_idx_d;
            pack_q       <= pack_d;
            mode_q       <= mode_d;
            armed_q      <= armed_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    gb_fb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_addr, push_data}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    // Head is masked while empty so the bus idles at FB_BASE with zero data.
    assign fb_write     = !fifo_empty;
    assign pop          = fb_write && !fb_waitrequest;
    assign fb_address   = fifo_empty ? FB_BASE : fifo_head[63:32];
    assign fb_writedata = fifo_empty ? 32'h0   : fifo_head[31:0];
    assign frame_done   = frame_done_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_gb_fb_writer.sv
// Directed bench for gb_fb_writer: transaction-level model with per-cycle compare.
module tb_gb_fb_writer;
    localparam logic [31:0] FB_BASE = 32'h0000_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lcd_en = 1'b1;
    logic [1:0]  ppu_mode = 2'd0;
    logic [7:0]  bgp = 8'hE4;
    logic [1:0]  px_in = 2'd0;
    logic        px_valid = 1'b0;
    logic [31:0] fb_address, fb_writedata;
    logic        fb_write;
    logic        fb_waitrequest = 1'b0;
    logic        frame_done, overflow;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    gb_fb_writer #(.FB_BASE(FB_BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .lcd_en         (lcd_en),
        .ppu_mode       (ppu_mode),
        .bgp            (bgp),
        .px_in          (px_in),
        .px_valid       (px_valid),
        .fb_address     (fb_address),
        .fb_writedata   (fb_writedata),
        .fb_write       (fb_write),
        .fb_waitrequest (fb_waitrequest),
        .frame_done     (frame_done),
        .overflow       (overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fb_addr(input int y, input int w);
        return FB_BASE + 32'((y * 10 + w) * 4);
    endfunction

    // Model state: pixel position, partial word, pending-write queue, flags
    int          mx, my, mwi;
    logic [31:0] mpack;
    logic [1:0]  mprev;
    bit          marmed, movf, mfd;
    logic [63:0] mq[$];

    always @(posedge clk) begin
        logic [63:0] ent;
        bit have;
        int yold;
        have = 0;
        ent = '0;
        if (!rst) begin
            mx = 0; my = 0; mwi = 0; mpack = '0; mprev = 2'd0;
            marmed = 1; movf = 0; mfd = 0;
            mq.delete();
        end else begin
            mfd = 0;
            yold = my;
            if (lcd_en) begin
                if (ppu_mode == 2'd3) marmed = 1;
                if (px_valid && ppu_mode == 2'd3 && mx < 160 && my < 144) begin
                    mpack[2*(mx%16) +: 2] = bgp[2*px_in +: 2];
                    if (mx % 16 == 15) begin
                        ent = {fb_addr(my, mwi), mpack};
                        have = 1;
                        mpack = '0;
                        mwi++;
                    end
                    mx++;
                end
                if (mprev == 2'd3 && ppu_mode == 2'd0) begin
                    if (mx % 16 != 0) begin
                        ent = {fb_addr(my, mwi), mpack};
                        have = 1;
                    end
                    mx = 0; mwi = 0; mpack = '0;
                    if (my < 144) my++;
                end
                if ((ppu_mode == 2'd1 && mprev != 2'd1) || yold == 144) begin
                    my = 0;
                    if (marmed) begin
                        mfd = 1;
                        marmed = 0;
                    end
                end
            end else begin
                mx = 0; my = 0; mwi = 0; mpack = '0;
            end
            mprev = ppu_mode;
            if (mq.size() > 0 && !fb_waitrequest) void'(mq.pop_front());
            if (have) begin
                if (mq.size() < DEPTH) mq.push_back(ent);
                else movf = 1;
            end
        end
    end

    logic [63:0] wlog[$];
    int fd_count = 0;
    int wr_hi = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fb_write", {63'd0, fb_write}, {63'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("fb_address", {32'd0, fb_address}, {32'd0, mq[0][63:32]});
                chk("fb_writedata", {32'd0, fb_writedata}, {32'd0, mq[0][31:0]});
            end else begin
                chk("idle_address", {32'd0, fb_address}, {32'd0, FB_BASE});
                chk("idle_writedata", {32'd0, fb_writedata}, 64'd0);
            end
            chk("overflow", {63'd0, overflow}, {63'd0, movf});
            chk("frame_done", {63'd0, frame_done}, {63'd0, mfd});
            if (fb_write && !fb_waitrequest) wlog.push_back({fb_address, fb_writedata});
            if (frame_done) fd_count++;
            if (fb_write) wr_hi++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        px_valid = 1'b0;
        ppu_mode = 2'd0;
        fb_waitrequest = 1'b0;
        lcd_en = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        wlog.delete();
        wr_hi = 0;
    endtask

    // Stream npx pixels in DRAW; sel 0 = constant cval, else index (i+seed)%4
    task automatic stream(input int npx, input int sel, input logic [1:0] cval, input int seed);
        for (int i = 0; i < npx; i++) begin
            px_in = (sel == 0) ? cval : 2'((i + seed) % 4);
            px_valid = 1'b1;
            tick();
        end
        px_valid = 1'b0;
    endtask

    task automatic draw_line(input int seed);
        ppu_mode = 2'd2;
        tick();
        ppu_mode = 2'd3;
        stream(160, 1, 2'd0, seed);
        ppu_mode = 2'd0;
        ticks(2);
    endtask

    initial begin
        int fd_base;
        do_reset();
        chk_en = 1;

        chk("rst_fb_write", {63'd0, fb_write}, 64'd0);
        chk("rst_address", {32'd0, fb_address}, {32'd0, FB_BASE});
        chk("rst_writedata", {32'd0, fb_writedata}, 64'd0);
        chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);

        // One full word of index 1 under the identity palette
        bgp = 8'hE4;
        ppu_mode = 2'd3;
        tick();
        stream(16, 0, 2'd1, 0);
        chk("t1_latency", {63'd0, fb_write}, 64'd1);
        ticks(3);
        chk("t1_count", 64'(wlog.size()), 64'd1);
        if (wlog.size() >= 1) chk("t1_word", wlog[0], {FB_BASE, 32'h5555_5555});
        chk("t1_write_cycles", 64'(wr_hi), 64'd1);

        // Reversed palette over a whole line
        do_reset();
        bgp = 8'h1B;
        ppu_mode = 2'd3;
        tick();
        stream(160, 1, 2'd0, 0);
        ticks(3);
        chk("t2_count", 64'(wlog.size()), 64'd10);
        for (int k = 0; k < 10 && k < wlog.size(); k++)
            chk("t2_word", wlog[k], {FB_BASE + 32'(4 * k), 32'h1B1B_1B1B});

        // Partial word flush at line end, next line starts at +40
        do_reset();
        bgp = 8'hE4;
        ppu_mode = 2'd3;
        tick();
        stream(5, 0, 2'd3, 0);
        ppu_mode = 2'd0;
        ticks(3);
        chk("t3_flush_count", 64'(wlog.size()), 64'd1);
        if (wlog.size() >= 1) chk("t3_flush", wlog[0], {FB_BASE, 32'h0000_03FF});
        ppu_mode = 2'd3;
        tick();
        stream(16, 0, 2'd0, 0);
        ticks(3);
        chk("t3_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() >= 2) chk("t3_next_line", {32'd0, wlog[1][63:32]}, {32'd0, FB_BASE + 32'd40});

        // Backpressure: four words queue, two are dropped
        do_reset();
        bgp = 8'hE4;
        fb_waitrequest = 1'b1;
        ppu_mode = 2'd3;
        tick();
        stream(96, 0, 2'd2, 0);
        ticks(20);
        chk("t4_overflow", {63'd0, overflow}, 64'd1);
        chk("t4_head_addr", {32'd0, fb_address}, {32'd0, FB_BASE});
        chk("t4_head_data", {32'd0, fb_writedata}, {32'd0, 32'hAAAA_AAAA});
        chk("t4_stalled_log", 64'(wlog.size()), 64'd0);
        fb_waitrequest = 1'b0;
        ticks(8);
        chk("t4_count", 64'(wlog.size()), 64'd4);
        for (int k = 0; k < 4 && k < wlog.size(); k++)
            chk("t4_word", wlog[k], {FB_BASE + 32'(4 * k), 32'hAAAA_AAAA});

        // Full frame, then V_BLANK
        do_reset();
        bgp = 8'hE4;
        fd_base = fd_count;
        for (int l = 0; l < 144; l++) draw_line(l);
        ppu_mode = 2'd1;
        ticks(10);
        chk("t5_count", 64'(wlog.size()), 64'd1440);
        if (wlog.size() >= 1440) chk("t5_last_addr", {32'd0, wlog[1439][63:32]}, {32'd0, FB_BASE + 32'd5756});
        chk("t5_frame_done", 64'(fd_count - fd_base), 64'd1);
        ppu_mode = 2'd2;
        tick();
        ppu_mode = 2'd3;
        stream(16, 0, 2'd1, 0);
        ppu_mode = 2'd0;
        ticks(3);
        chk("t5_next_count", 64'(wlog.size()), 64'd1441);
        if (wlog.size() >= 1441) chk("t5_next_frame", wlog[1440], {FB_BASE, 32'h5555_5555});

        // Reset mid-line with writes pending under backpressure
        do_reset();
        fb_waitrequest = 1'b1;
        ppu_mode = 2'd3;
        tick();
        stream(40, 0, 2'd1, 0);
        rst = 1'b0;
        tick();
        chk("t6_fb_write", {63'd0, fb_write}, 64'd0);
        chk("t6_overflow", {63'd0, overflow}, 64'd0);
        chk("t6_address", {32'd0, fb_address}, {32'd0, FB_BASE});
        rst = 1'b1;
        fb_waitrequest = 1'b0;
        wlog.delete();
        stream(16, 0, 2'd3, 0);
        ticks(3);
        chk("t6_count", 64'(wlog.size()), 64'd1);
        if (wlog.size() >= 1) chk("t6_word", wlog[0], {FB_BASE, 32'hFFFF_FFFF});

        // LCD disabled: pixels ignored
        do_reset();
        lcd_en = 1'b0;
        ppu_mode = 2'd3;
        tick();
        stream(32, 0, 2'd1, 0);
        ppu_mode = 2'd1;
        ticks(3);
        chk("t7_count", 64'(wlog.size()), 64'd0);
        lcd_en = 1'b1;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
